// File: rtl/mmio_cmd_fifo.sv
// MMIO command FIFO: DEPTH x WIDTH circular buffer with first-word fall-through
// read data, registered occupancy flags and sticky overflow/underflow flags.
module mmio_cmd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic                     clr_flags,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             pop_ok;
  logic             push_ok;
  logic [CW-1:0]    count_nxt;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
  assign pop_ok  = rd_en & ~empty;
  assign push_ok = wr_en & (~full | pop_ok);

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok)  rp <= rp + AW'(1);
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == CW'(DEPTH));
      // A new event wins over a simultaneous clear.
      overflow  <= (overflow  & ~clr_flags) | (wr_en & ~push_ok);
      underflow <= (underflow & ~clr_flags) | (rd_en & empty);
    end
  end

  // Storage is data only: never reset, written only on an accepted push outside reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem[wp] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rp];

endmodule

// File: tb/tb_mmio_cmd_fifo.sv
// Scoreboard testbench for mmio_cmd_fifo (WIDTH=64, DEPTH=8).
module tb_mmio_cmd_fifo;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             clr_flags;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [3:0]       count;
  logic             overflow;
  logic             underflow;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sbq[$];
  int mcnt = 0;

  always #5 clk = ~clk;

  mmio_cmd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_flags(clr_flags), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle; samples the head word before the edge and tracks accepted pushes in the scoreboard.
  task automatic drive(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c,
                       output logic [WIDTH-1:0] got, output logic popped);
    logic pa, wa;
    wr_en = w; wr_data = d; rd_en = r; clr_flags = c;
    #1;
    got = rd_data;
    pa = r && (mcnt > 0);
    wa = w && ((mcnt < DEPTH) || pa);
    if (wa) sbq.push_back(d);
    mcnt = mcnt + int'(wa) - int'(pa);
    popped = pa;
    cyc;
    wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    cyc;
    rst_n = 1'b1;
    sbq.delete();
    mcnt = 0;
  endtask

  task automatic test_reset;
    wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0; wr_data = '0;
    do_reset;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
        underflow !== 1'b0 || rd_data !== 64'd0) begin
      errors++;
      $display("FAIL reset: count=%0d empty=%b full=%b ovf=%b unf=%b rd=%0h, want 0 1 0 0 0 0",
               count, empty, full, overflow, underflow, rd_data);
    end
  endtask

  task automatic test_basic;
    logic [WIDTH-1:0] got, exp;
    logic pd;
    drive(1'b1, 64'hA5, 1'b0, 1'b0, got, pd);
    checks++;
    if (rd_data !== 64'hA5 || count !== 4'd1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL basic_push: rd=%0h count=%0d empty=%b, want a5 1 0", rd_data, count, empty);
    end
    drive(1'b0, '0, 1'b1, 1'b0, got, pd);
    exp = sbq.pop_front();
    checks++;
    if (!pd || got !== exp) begin
      errors++;
      $display("FAIL basic_pop: got %0h want %0h", got, exp);
    end
    checks++;
    if (empty !== 1'b1 || rd_data !== 64'd0 || count !== 4'd0) begin
      errors++;
      $display("FAIL basic_empty: empty=%b rd=%0h count=%0d, want 1 0 0", empty, rd_data, count);
    end
  endtask

  task automatic test_fill_overflow;
    logic [WIDTH-1:0] got, exp;
    logic pd;
    for (int i = 1; i <= 8; i++) drive(1'b1, 64'(i), 1'b0, 1'b0, got, pd);
    checks++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d ovf=%b, want 1 8 0", full, count, overflow);
    end
    drive(1'b1, 64'd9, 1'b0, 1'b0, got, pd);
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow: ovf=%b count=%0d full=%b, want 1 8 1", overflow, count, full);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, got, pd);
      exp = sbq.pop_front();
      checks++;
      if (!pd || got !== exp) begin
        errors++;
        $display("FAIL fill_pop%0d: got %0h want %0h", i, got, exp);
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 4'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drained: empty=%b count=%0d ovf=%b, want 1 0 1", empty, count, overflow);
    end
    drive(1'b0, '0, 1'b0, 1'b1, got, pd);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_wrap;
    logic [WIDTH-1:0] got, exp;
    logic pd;
    do_reset;
    for (int i = 0; i < 5; i++) drive(1'b1, 64'h50 + 64'(i), 1'b0, 1'b0, got, pd);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, got, pd);
      exp = sbq.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL wrap_pre%0d: got %0h want %0h", i, got, exp);
      end
    end
    for (int i = 0; i < 8; i++) drive(1'b1, 64'h10 + 64'(i), 1'b0, 1'b0, got, pd);
    checks++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_full: full=%b count=%0d ovf=%b, want 1 8 0", full, count, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, got, pd);
      exp = sbq.pop_front();
      checks++;
      if (got !== exp || got !== 64'h10 + 64'(i)) begin
        errors++;
        $display("FAIL wrap_pop%0d: got %0h want %0h", i, got, 64'h10 + 64'(i));
      end
    end
  endtask

  task automatic test_full_simul;
    logic [WIDTH-1:0] got, exp;
    logic pd;
    for (int i = 0; i < 8; i++) drive(1'b1, 64'h20 + 64'(i), 1'b0, 1'b0, got, pd);
    drive(1'b1, 64'h99, 1'b1, 1'b0, got, pd);
    exp = sbq.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL full_simul_head: got %0h want %0h", got, exp);
    end
    checks++;
    if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_simul: count=%0d full=%b ovf=%b, want 8 1 0", count, full, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, got, pd);
      exp = sbq.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL full_simul_pop%0d: got %0h want %0h", i, got, exp);
      end
    end
    checks++;
    if (got !== 64'h99 || empty !== 1'b1) begin
      errors++;
      $display("FAIL full_simul_last: got %0h empty=%b, want 99 1", got, empty);
    end
  endtask

  task automatic test_empty_simul;
    logic [WIDTH-1:0] got, exp;
    logic pd;
    drive(1'b1, 64'h77, 1'b1, 1'b0, got, pd);
    checks++;
    if (pd || got !== 64'd0) begin
      errors++;
      $display("FAIL empty_simul_head: got %0h want 0", got);
    end
    checks++;
    if (underflow !== 1'b1 || count !== 4'd1 || rd_data !== 64'h77 || empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_simul: unf=%b count=%0d rd=%0h empty=%b, want 1 1 77 0",
               underflow, count, rd_data, empty);
    end
    drive(1'b0, '0, 1'b0, 1'b1, got, pd);
    checks++;
    if (underflow !== 1'b0 || count !== 4'd1) begin
      errors++;
      $display("FAIL unf_clear: unf=%b count=%0d, want 0 1", underflow, count);
    end
    drive(1'b0, '0, 1'b1, 1'b0, got, pd);
    exp = sbq.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL empty_simul_pop: got %0h want %0h", got, exp);
    end
    // Underflow event and clear in the same cycle: the event must win.
    drive(1'b0, '0, 1'b1, 1'b1, got, pd);
    checks++;
    if (underflow !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL clr_priority: unf=%b count=%0d, want 1 0", underflow, count);
    end
  endtask

  task automatic test_reset_mid;
    logic [WIDTH-1:0] got;
    logic pd;
    for (int i = 0; i < 3; i++) drive(1'b1, 64'h30 + 64'(i), 1'b0, 1'b0, got, pd);
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL pre_reset_count: count=%0d want 3", count);
    end
    wr_en = 1'b1; wr_data = 64'hDEAD;
    do_reset;
    wr_en = 1'b0;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
        underflow !== 1'b0 || rd_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid: count=%0d empty=%b full=%b ovf=%b unf=%b rd=%0h, want 0 1 0 0 0 0",
               count, empty, full, overflow, underflow, rd_data);
    end
    cyc;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_wr_ignored: count=%0d empty=%b, want 0 1", count, empty);
    end
    drive(1'b1, 64'h44, 1'b0, 1'b0, got, pd);
    checks++;
    if (rd_data !== 64'h44 || count !== 4'd1) begin
      errors++;
      $display("FAIL post_reset_push: rd=%0h count=%0d, want 44 1", rd_data, count);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_fill_overflow;
    test_wrap;
    test_full_simul;
    test_empty_simul;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_cmd_fifo.md
MMIO_CMD_FIFO -- requirements
Module: mmio_cmd_fifo

Interface
REQ-001 Parameter WIDTH, default 64: data word width in bits.
REQ-002 Parameter DEPTH, default 8: number of entries; a power of two, at least 2.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset, synchronous, active-low.
REQ-005 wr_en  input  1: push request, driven by the MMIO write decode (mmioWrValid and address match).
REQ-006 wr_data  input  WIDTH: push data, the MMIO write payload bits [WIDTH-1:0].
REQ-007 rd_en  input  1: pop request, driven by the MMIO read decode of the FIFO data address.
REQ-008 rd_data  output  WIDTH: head-of-queue word (first-word fall-through).
REQ-009 empty  output  1: asserted when count equals 0.
REQ-010 full  output  1: asserted when count equals DEPTH.
REQ-011 count  output  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-012 overflow  output  1: sticky flag; set by a push attempted while full.
REQ-013 underflow  output  1: sticky flag; set by a pop attempted while empty.
REQ-014 clr_flags  input  1: clears overflow and underflow on the next clock edge.

Function
REQ-015 Storage SHALL be a DEPTH x WIDTH circular buffer with write pointer wp and read pointer rp, each $clog2(DEPTH) bits wide, wrapping from DEPTH-1 to 0.
REQ-016 An accepted push SHALL store wr_data at wp, increment wp and increment count; a push is accepted when wr_en=1 and (full=0 or an accepted pop occurs in the same cycle).
REQ-017 An accepted pop SHALL increment rp and decrement count; a pop is accepted when rd_en=1 and empty=0.
REQ-018 rd_data SHALL combinationally present mem[rp] while empty=0, and SHALL present 0 while empty=1.
REQ-019 Push-to-visible latency: a word pushed into an empty FIFO SHALL appear on rd_data, with empty=0, in the cycle after the push edge.
REQ-020 Simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 When the FIFO is full, a simultaneous push and pop SHALL both be accepted; overflow SHALL NOT be set.
REQ-022 When the FIFO is empty, a simultaneous push and pop: the push SHALL be accepted, the pop rejected, underflow set, and count becomes 1.
REQ-023 A rejected push SHALL drop wr_data, leave memory and wp unchanged, and set overflow.
REQ-024 A rejected pop SHALL leave rp unchanged and set underflow.
REQ-025 If clr_flags=1 in the same cycle as a new overflow or underflow event, the flag SHALL be set; the event takes priority over the clear.
REQ-026 empty, full and count SHALL be registered state, mutually consistent in every cycle, and SHALL never show count greater than DEPTH.

Reset
REQ-027 When rst_n=0 at a clock edge: wp=0, rp=0, count=0, empty=1, full=0, overflow=0, underflow=0, and rd_data=0.
REQ-028 Memory contents SHALL NOT be reset; an empty FIFO never exposes them.
REQ-029 Reset asserted mid-operation SHALL discard all queued words; wr_en and rd_en in a reset cycle SHALL be ignored.

Verification
REQ-030 Reset, then push 0xA5 -> next cycle rd_data=0xA5, count=1, empty=0; pop -> next cycle empty=1, rd_data=0.
REQ-031 Push 1..8 (DEPTH=8) -> full=1, count=8; push 9 -> overflow=1, count=8; pop 8 times -> data 1..8 in order, then empty=1.
REQ-032 Wrap-around: 5 pushes, 5 pops, then 8 pushes of 0x10..0x17 -> pops return 0x10..0x17 in order, with pointers wrapped past 7.
REQ-033 Full FIFO, simultaneous push 0x99 and pop -> count stays 8, overflow=0; the last of the 8 subsequent pops returns 0x99.
REQ-034 Empty FIFO, simultaneous push 0x77 and pop -> underflow=1, count=1, rd_data=0x77; clr_flags pulse -> underflow=0.
REQ-035 Push 3 words, then rst_n=0 for 1 cycle together with wr_en=1 -> count=0, empty=1, flags 0, and the wr_en in the reset cycle is ignored.
